// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_resp
//  Purpose  : Single-port data memory with a valid/ready request channel and
//             a valid/ready response channel. Each access takes a fixed
//             number of cycles. Supports B/H/W/D loads and stores, with sign
//             or zero extension on loads. Faulting accesses (misaligned,
//             out of range, illegal op) leave memory untouched and return
//             rsp_err=1 with rsp_rdata=0.
//  Ports    : clk, rst_n   - clock, synchronous active-low reset
//             req_valid/req_ready, req_wr, req_op[2:0], req_addr, req_wdata
//                          - request channel (funct3-encoded op)
//             rsp_valid/rsp_ready, rsp_rdata, rsp_err
//                          - response channel
//  Notes    : Lane selection assumes 64-bit (8-byte) words.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_resp #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = 64'h80000000,
  parameter int unsigned     WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned     IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH_WORDS) << 3;
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;

  logic            lat_wr;
  logic [2:0]      lat_op;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic handshake;
  logic commit;

  assign handshake = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The access happens on the edge that enters RESP.
  assign commit = (state != RESP) && (state_nxt == RESP);

  // ---------------------------------------------------------------------------
  // Access datapath. With zero wait states the commit edge is also the
  // handshake edge, so the live request is used instead of the latched copy.
  // ---------------------------------------------------------------------------
  logic            acc_wr;
  logic [2:0]      acc_op;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;

  assign acc_wr    = (state == IDLE) ? req_wr    : lat_wr;
  assign acc_op    = (state == IDLE) ? req_op    : lat_op;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  logic [XLEN-1:0] off;
  logic [IDXW-1:0] idx;
  logic [2:0]      lane;
  logic            misalign;
  logic            oob;
  logic            fault;
  logic [7:0]      be;
  logic [7:0]      be_sh;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] rd_sh;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] acc_rdata;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets and
  // are caught by the range compare.
  assign off  = acc_addr - BASE_ADDR;
  assign idx  = off[IDXW+2:3];
  assign lane = acc_addr[2:0];
  assign oob  = (off >= MEM_BYTES);

  always_comb begin
    misalign = 1'b0;
    be       = 8'h01;
    case (acc_op[1:0])
      2'd0: begin misalign = 1'b0;               be = 8'h01; end
      2'd1: begin misalign = acc_addr[0];        be = 8'h03; end
      2'd2: begin misalign = |acc_addr[1:0];     be = 8'h0F; end
      default: begin misalign = |acc_addr[2:0];  be = 8'hFF; end
    endcase
  end

  assign fault    = misalign || oob || (acc_wr && acc_op[2]) || (acc_op == 3'b111);
  assign be_sh    = be << lane;
  assign wdata_sh = acc_wdata << {lane, 3'b000};
  assign rd_word  = mem[idx];
  assign rd_sh    = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_val = '0;
    case (acc_op)
      3'b000:  ld_val = {{(XLEN-8){rd_sh[7]}},   rd_sh[7:0]};
      3'b001:  ld_val = {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b010:  ld_val = {{(XLEN-32){rd_sh[31]}}, rd_sh[31:0]};
      3'b011:  ld_val = rd_sh;
      3'b100:  ld_val = {{(XLEN-8){1'b0}},  rd_sh[7:0]};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, rd_sh[15:0]};
      3'b110:  ld_val = {{(XLEN-32){1'b0}}, rd_sh[31:0]};
      default: ld_val = '0;
    endcase
  end

  assign acc_rdata = (fault || acc_wr) ? '0 : ld_val;

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_op    <= 3'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (handshake) begin
        lat_wr    <= req_wr;
        lat_op    <= req_op;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_rdata <= acc_rdata;
        rsp_err   <= fault;
      end
    end
  end

  // Storage is never cleared; a store whose commit edge sees reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && commit && acc_wr && !fault) begin
      for (int b = 0; b < 8; b++) begin
        if (be_sh[b]) begin
          mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_resp
//  Purpose  : Self-checking bench for dmem_resp. Four instances with 0, 1, 3
//             and 15 wait states share the request fields; each has its own
//             valid/ready lines. A byte-addressed reference model predicts
//             every response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

  localparam logic [63:0] BASE  = 64'h80000000;
  localparam int          DEPTH = 4096;
  localparam int          NDUT  = 4;

  logic        clk;
  logic        rst_n;
  logic        req_wr;
  logic [2:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        req_valid_v [NDUT];
  logic        req_ready_v [NDUT];
  logic        rsp_valid_v [NDUT];
  logic        rsp_ready_v [NDUT];
  logic [63:0] rsp_rdata_v [NDUT];
  logic        rsp_err_v   [NDUT];

  int checks = 0;
  int errors = 0;

  // Reference storage, one byte per entry, keyed by instance and byte offset.
  bit [7:0] mdl [longint];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : (d == 2) ? 3 : 15;
  endfunction

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dmem_resp #(
        .XLEN        (64),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_v[g]),
        .req_ready (req_ready_v[g]),
        .req_wr    (req_wr),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid_v[g]),
        .rsp_ready (rsp_ready_v[g]),
        .rsp_rdata (rsp_rdata_v[g]),
        .rsp_err   (rsp_err_v[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout errors=%0d", errors);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one access: size, alignment, range and op legality
  // rules applied to a flat byte store.
  function automatic void model(input int d, input bit wr, input bit [2:0] op,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                output logic [63:0] rd, output logic er);
    longint unsigned size;
    logic [63:0]     offs;
    logic [63:0]     v;
    longint          key;
    size = 64'd1 << op[1:0];
    offs = addr - BASE;
    v    = 64'd0;
    rd   = 64'd0;
    er   = ((addr % size) != 0) || (offs >= 64'(DEPTH) * 8) || (wr && op[2]) || (op == 3'b111);
    if (er) return;
    for (int i = 0; i < int'(size); i++) begin
      key = longint'(d) * 65536 + longint'(offs) + longint'(i);
      if (wr) mdl[key] = wdata[8*i +: 8];
      else    v = v | (64'(mdl[key]) << (8*i));
    end
    if (!wr) begin
      if (size < 8 && !op[2] && v[8*size-1]) v = v | (~64'd0 << (8*size));
      rd = v;
    end
  endfunction

  // One complete transaction on instance d, with `hold` cycles of response
  // backpressure. Checks latency, stability under backpressure, the return to
  // IDLE and the response against the model.
  task automatic txn(input int d, input bit wr, input bit [2:0] op,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input int hold, output logic [63:0] rd, output logic er);
    int          n;
    int          lat;
    logic [63:0] exp_rd;
    logic        exp_er;
    n = 0;
    while (req_ready_v[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before", 64'(req_ready_v[d]), 64'd1);
    @(negedge clk);
    req_valid_v[d] = 1'b1;
    req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid_v[d] = 1'b0;
    // Scramble the request fields: the pending access must not see them.
    req_wr    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    model(d, wr, op, addr, wdata, exp_rd, exp_er);
    lat = 1;
    while (rsp_valid_v[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(wait_of(d) + 1));
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 64'(rsp_valid_v[d]), 64'd1);
      check("bp_rdata", rsp_rdata_v[d], exp_rd);
      check("bp_ready", 64'(req_ready_v[d]), 64'd0);
      @(posedge clk); #1;
    end
    rd = rsp_rdata_v[d];
    er = rsp_err_v[d];
    check("rsp_rdata", rd, exp_rd);
    check("rsp_err", 64'(er), 64'(exp_er));
    @(negedge clk);
    rsp_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready_v[d] = 1'b0;
    check("idle_valid", 64'(rsp_valid_v[d]), 64'd0);
    check("idle_ready", 64'(req_ready_v[d]), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [63:0] a;
    bit          wr;
    bit [2:0]    op;

    rst_n = 1'b0;
    req_wr = 1'b0; req_op = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    for (int d = 0; d < NDUT; d++) begin
      req_valid_v[d] = 1'b0;
      rsp_ready_v[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("rst_rsp_valid", 64'(rsp_valid_v[d]), 64'd0);
      check("rst_rsp_rdata", rsp_rdata_v[d], 64'd0);
      check("rst_rsp_err", 64'(rsp_err_v[d]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) check("rst_req_ready", 64'(req_ready_v[d]), 64'd1);

    // Store then load on the 1-wait-state instance.
    txn(1, 1, 3'b011, 64'h80000010, 64'h1122334455667788, 0, rd, er);
    check("sd_rdata", rd, 64'd0);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("ld_basic", rd, 64'h1122334455667788);
    check("ld_basic_err", 64'(er), 64'd0);

    // Byte lanes.
    txn(1, 1, 3'b000, 64'h80000013, 64'h00000000000000FF, 0, rd, er);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("ld_after_sb", rd, 64'h11223344FF667788);
    txn(1, 0, 3'b000, 64'h80000013, 64'd0, 0, rd, er);
    check("lb", rd, 64'hFFFFFFFFFFFFFFFF);
    txn(1, 0, 3'b100, 64'h80000013, 64'd0, 0, rd, er);
    check("lbu", rd, 64'h00000000000000FF);
    txn(1, 0, 3'b101, 64'h80000012, 64'd0, 0, rd, er);
    check("lhu", rd, 64'h000000000000FF66);

    // Faults, each followed by a reload proving the word is unchanged.
    txn(1, 1, 3'b010, 64'h80000012, 64'hAAAAAAAAAAAAAAAA, 0, rd, er);
    check("flt_misalign_err", 64'(er), 64'd1);
    check("flt_misalign_rd", rd, 64'd0);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("flt_misalign_mem", rd, 64'h11223344FF667788);
    txn(1, 0, 3'b011, 64'h7FFFFFF8, 64'd0, 0, rd, er);
    check("flt_below_err", 64'(er), 64'd1);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("flt_below_mem", rd, 64'h11223344FF667788);
    txn(1, 1, 3'b011, BASE + 64'(DEPTH) * 8, 64'h5555555555555555, 0, rd, er);
    check("flt_above_err", 64'(er), 64'd1);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("flt_above_mem", rd, 64'h11223344FF667788);
    txn(1, 1, 3'b100, 64'h80000010, 64'h0000000000000033, 0, rd, er);
    check("flt_stop_err", 64'(er), 64'd1);
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("flt_stop_mem", rd, 64'h11223344FF667788);

    // Backpressure for 5 cycles.
    txn(1, 0, 3'b011, 64'h80000010, 64'd0, 5, rd, er);
    check("bp_final", rd, 64'h11223344FF667788);

    // Latency sweep on 0 and 15 wait states.
    txn(0, 1, 3'b011, 64'h80000010, 64'h1122334455667788, 0, rd, er);
    txn(0, 0, 3'b011, 64'h80000010, 64'd0, 0, rd, er);
    check("w0_ld", rd, 64'h1122334455667788);
    txn(3, 1, 3'b011, 64'h80000010, 64'h1122334455667788, 0, rd, er);
    txn(3, 0, 3'b011, 64'h80000010, 64'd0, 2, rd, er);
    check("w15_ld", rd, 64'h1122334455667788);

    // Reset during WAIT on the 3-wait-state instance drops the store.
    txn(2, 1, 3'b011, 64'h80000020, 64'h0123456789ABCDEF, 0, rd, er);
    @(negedge clk);
    req_valid_v[2] = 1'b1;
    req_wr = 1'b1; req_op = 3'b011; req_addr = 64'h80000020; req_wdata = 64'h000000000000DEAD;
    @(posedge clk); #1;
    req_valid_v[2] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw_valid", 64'(rsp_valid_v[2]), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstw_valid_rel", 64'(rsp_valid_v[2]), 64'd0);
    check("rstw_ready_rel", 64'(req_ready_v[2]), 64'd1);
    check("rstw_err_rel", 64'(rsp_err_v[2]), 64'd0);
    txn(2, 0, 3'b011, 64'h80000020, 64'd0, 0, rd, er);
    check("rstw_mem", rd, 64'h0123456789ABCDEF);

    // Randomized traffic: fill a small window, then mixed ops incl. faults.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 16; w++) begin
        txn(d, 1, 3'b011, BASE + 64'(w * 8), {$urandom, $urandom}, 0, rd, er);
      end
      for (int n = 0; n < 40; n++) begin
        wr = 1'($urandom);
        op = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0:       a = BASE - 64'($urandom_range(1, 64));
          1:       a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 64));
          default: a = BASE + 64'($urandom_range(0, 127));
        endcase
        txn(d, wr, op, a, {$urandom, $urandom}, $urandom_range(0, 2), rd, er);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning data and address width.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of XLEN-bit storage words.
REQ-003 The block SHALL have parameter BASE_ADDR, default 64'h80000000, meaning the byte address of word 0.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the number of added wait states per access.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: request may be accepted.
REQ-009 The block SHALL have port req_wr, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port req_op, input, 3 bits: access type using funct3 encoding. 000 = B, 001 = H, 010 = W, 011 = D, 100 = BU, 101 = HU, 110 = WU.
REQ-011 The block SHALL have port req_addr, input, XLEN bits: byte address.
REQ-012 The block SHALL have port req_wdata, input, XLEN bits: store data, right-aligned.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-015 The block SHALL have port rsp_rdata, output, XLEN bits: load result, already extended.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: access fault for this response.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 rsp_valid SHALL be 1 only in RESP.
REQ-020 A handshake SHALL occur when req_valid=1 and req_ready=1 at a rising edge. On a handshake the block SHALL latch wr, op, addr and wdata.
REQ-021 On a handshake, if WAIT_CYCLES=0 the FSM SHALL go IDLE->RESP. Otherwise it SHALL go IDLE->WAIT and load the wait counter with WAIT_CYCLES.
REQ-022 In WAIT the counter SHALL decrement each cycle. When the counter is 1, the FSM SHALL move to RESP on the next edge.
REQ-023 The access SHALL be performed on the edge that enters RESP. This covers both the memory write and the capture of rsp_rdata and rsp_err.
REQ-024 Latency SHALL be fixed: handshake at edge T gives rsp_valid high from edge T+1+WAIT_CYCLES.
REQ-025 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1 at an edge; the FSM SHALL then go to IDLE.
REQ-026 A new request SHALL NOT be accepted in the same cycle as a response handshake. Minimum spacing between accepts SHALL be WAIT_CYCLES+2 cycles.
REQ-027 Access size SHALL be 1, 2, 4 or 8 bytes, given by req_op[1:0].
REQ-028 The word index SHALL be (addr-BASE_ADDR)>>3, and the lane offset SHALL be addr[2:0].
REQ-029 The fault condition SHALL be any of the following:
  - addr not aligned to the access size;
  - (addr-BASE_ADDR) >= DEPTH_WORDS*8, unsigned, so addr < BASE_ADDR wraps and faults;
  - a store with req_op[2]=1;
  - req_op=111.
REQ-030 On a fault the block SHALL write no memory, set rsp_rdata=0 and set rsp_err=1.
REQ-031 On a good access rsp_err SHALL be 0.
REQ-032 A store SHALL write only the size bytes starting at lane offset, taken from the low size bytes of wdata. All other bytes of the word SHALL be unchanged. rsp_rdata SHALL be 0 for a store.
REQ-033 A load SHALL extract size bytes at the lane offset. Ops 0xx SHALL sign-extend and ops 1xx SHALL zero-extend; D SHALL be returned unmodified.
REQ-034 A load issued after a completed store to the same word SHALL return the stored data. No read-before-write hazard is permitted.
REQ-035 req_* inputs SHALL be ignored outside IDLE. Changes to them during WAIT or RESP SHALL NOT affect the pending access.

Reset
REQ-036 While rst_n=0 at an edge, the block SHALL force:
  - FSM = IDLE and counter = 0;
  - req_ready = 1 after release, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - all latched request fields = 0.
REQ-037 Memory contents SHALL NOT be cleared by reset.
REQ-038 A store whose commit edge coincides with rst_n=0, or that is still in WAIT when reset occurs, SHALL NOT be written.
REQ-039 A request presented in the cycle reset deasserts SHALL NOT be accepted until the first edge with rst_n=1.

Verification
REQ-040 Word store then load, WAIT_CYCLES=1: SD 0x1122334455667788 to 0x80000010, then LD 0x80000010 -> rsp_rdata=0x1122334455667788, rsp_err=0, and rsp_valid 2 cycles after each accept.
REQ-041 Byte lanes: after REQ-040, SB 0xFF to 0x80000013, then run the following loads:
  - LD -> 0x11223344FF667788;
  - LB 0x80000013 -> 0xFFFFFFFFFFFFFFFF;
  - LBU -> 0x00000000000000FF;
  - LHU 0x80000012 -> 0x000000000000FF66.
REQ-042 Faults, each followed by an LD of 0x80000010 that shows the memory word unchanged:
  - SW to 0x80000012 (misaligned) -> rsp_err=1, rsp_rdata=0;
  - LD 0x7FFFFFF8 (below base) -> rsp_err=1;
  - SD to BASE_ADDR+DEPTH_WORDS*8 -> rsp_err=1;
  - store with req_op=100 -> rsp_err=1.
REQ-043 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; raise rsp_ready -> IDLE on the next edge.
REQ-044 Reset mid-operation, WAIT_CYCLES=3: accept SD 0xDEAD to 0x80000020 and assert rst_n=0 during WAIT -> rsp_valid=0 and req_ready=1 after release; a subsequent LD of 0x80000020 returns the pre-existing contents.
REQ-045 Parameter sweep: repeat REQ-040 with WAIT_CYCLES=0 and 15 -> latency of 1 and 16 cycles respectively.
